// File: rtl/vga_frame_writer_if.sv
// Pixel plot request channel between a drawing client (master) and the
// frame-buffer writer (slave).
interface vga_frame_writer_if;
    logic        px_valid;
    logic        px_ready;
    logic [10:0] px_x;
    logic [10:0] px_y;
    logic        px_val;

    modport master (output px_valid, px_x, px_y, px_val, input px_ready);
    modport slave  (input px_valid, px_x, px_y, px_val, output px_ready);
endinterface

// File: rtl/vga_frame_writer.sv
// Write-side controller for a 1-bpp frame buffer: single-pixel read-modify-write
// plots plus a full-screen fill engine that streams one word per clock.
module vga_frame_writer #(
    parameter int H_RES  = 800,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    vga_frame_writer_if.slave px,
    input  logic              fill_start,
    input  logic              fill_val,
    output logic              busy,
    output logic              done,
    output logic              drop,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [15:0]       ram_rd_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [15:0]       ram_wr_data,
    output logic              ram_we
);
    localparam int WORDS = H_RES * V_RES / 16;

    typedef enum logic [1:0] {IDLE, READ, MODIFY, FILL} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] word_q;
    logic [ADDR_W-1:0] fill_cnt;
    logic [3:0]        bit_q;
    logic              px_val_q;
    logic              fill_val_q;
    logic [18:0]       pn;
    logic              in_range;
    logic              accept;
    logic              fill_last;

    assign pn        = 19'(px.px_x) + 19'(px.px_y) * 19'(H_RES);
    assign in_range  = (px.px_x < 11'(H_RES)) && (px.px_y < 11'(V_RES));
    // Fill wins over a simultaneous pixel request, so the request is not taken.
    assign accept    = (state == IDLE) && !fill_start && px.px_valid;
    assign fill_last = (fill_cnt == ADDR_W'(WORDS - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx    = state;
        px.px_ready = 1'b0;
        busy        = 1'b1;
        ram_rd_addr = '0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_we      = 1'b0;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                px.px_ready = !fill_start;
                if (fill_start)                      state_nx = FILL;
                else if (px.px_valid && in_range)    state_nx = READ;
            end
            READ: begin
                ram_rd_addr = word_q;
                state_nx    = MODIFY;
            end
            MODIFY: begin
                // Read data arrives this cycle from the address issued in READ.
                ram_we             = 1'b1;
                ram_wr_addr        = word_q;
                ram_wr_data        = ram_rd_data;
                ram_wr_data[bit_q] = px_val_q;
                state_nx           = IDLE;
            end
            FILL: begin
                ram_we      = 1'b1;
                ram_wr_addr = fill_cnt;
                ram_wr_data = {16{fill_val_q}};
                if (fill_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q     <= '0;
            bit_q      <= '0;
            px_val_q   <= 1'b0;
            fill_val_q <= 1'b0;
            fill_cnt   <= '0;
            done       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            done <= (state == MODIFY) || ((state == FILL) && fill_last);
            drop <= accept && !in_range;
            if (accept && in_range) begin
                word_q   <= ADDR_W'(pn >> 4);
                bit_q    <= pn[3:0];
                px_val_q <= px.px_val;
            end
            if ((state == IDLE) && fill_start) begin
                fill_val_q <= fill_val;
                fill_cnt   <= '0;
            end else if (state == FILL) begin
                fill_cnt <= fill_cnt + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer: table of pixel plots against a registered
// RAM model, then hand-written fill, fill-priority and mid-fill reset sequences.
module tb_vga_frame_writer;
    localparam int ADDR_W = 16;

    typedef struct {
        string       name;
        logic [10:0] x;
        logic [10:0] y;
        logic        val;
        logic        preload;
        logic [15:0] pre_addr;
        logic [15:0] pre_data;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fill_start, fill_val;
    logic              busy, done, drop, ram_we;
    logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr;
    logic [15:0]       ram_rd_data, ram_wr_data;

    logic              pre_we = 1'b0;
    logic [15:0]       pre_addr, pre_data;
    logic [15:0]       mem [0:65535];
    int                wr_cnt = 0;
    int                done_cnt = 0;
    logic [15:0]       last_addr, last_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_frame_writer_if px_bus();

    vga_frame_writer #(.H_RES(800), .V_RES(480), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .px          (px_bus),
        .fill_start  (fill_start),
        .fill_val    (fill_val),
        .busy        (busy),
        .done        (done),
        .drop        (drop),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_we      (ram_we)
    );

    // Registered-read RAM; a write is visible to any read issued on a later edge.
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr]    <= pre_data;
        else if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    always @(posedge clk) begin
        if (ram_we) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= ram_wr_addr;
            last_data <= ram_wr_data;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where done/drop is observed.
    task automatic run_plot(input vec_t v, output int waits);
        int base_wr;
        int lat;
        int rdy_low;
        bit got;
        if (v.preload) preload(v.pre_addr, v.pre_data);
        base_wr = wr_cnt;
        px_bus.px_x     = v.x;
        px_bus.px_y     = v.y;
        px_bus.px_val   = v.val;
        px_bus.px_valid = 1'b1;
        got   = 1'b0;
        waits = 0;
        for (int c = 0; c < 30000 && !got; c++) begin
            if (px_bus.px_ready) got = 1'b1;
            else                 waits++;
            @(negedge clk);
        end
        px_bus.px_valid = 1'b0;
        check({v.name, "_accepted"}, 32'(got), 32'd1);
        lat     = 0;
        rdy_low = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!px_bus.px_ready) rdy_low++;
            if (done || drop) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (v.exp_we) begin
            check({v.name, "_latency"}, 32'(lat), 32'd3);
            check({v.name, "_done"}, 32'(done), 32'd1);
            check({v.name, "_drop"}, 32'(drop), 32'd0);
            check({v.name, "_ready_low"}, 32'(rdy_low), 32'd2);
            check({v.name, "_writes"}, 32'(wr_cnt - base_wr), 32'd1);
            check({v.name, "_wr_addr"}, 32'(last_addr), 32'(v.exp_addr));
            check({v.name, "_wr_data"}, 32'(last_data), 32'(v.exp_data));
        end else begin
            check({v.name, "_drop_lat"}, 32'(lat), 32'd1);
            check({v.name, "_drop"}, 32'(drop), 32'd1);
            check({v.name, "_done"}, 32'(done), 32'd0);
            @(negedge clk);
            check({v.name, "_drop_pulse"}, 32'(drop), 32'd0);
            check({v.name, "_done_after"}, 32'(done), 32'd0);
            check({v.name, "_writes"}, 32'(wr_cnt - base_wr), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[9];
        vec_t fv;
        int   waits;
        int   base_wr, base_done;
        int   nwr, nerr, ndone_mid;
        bit   reached;

        vecs[0] = '{"p0_0",      11'd0,    11'd0,    1'b1, 1'b1, 16'd0,     16'h0000, 1'b1, 16'd0,     16'h0001};
        vecs[1] = '{"p17_1",     11'd17,   11'd1,    1'b1, 1'b1, 16'd51,    16'h0000, 1'b1, 16'd51,    16'h0002};
        vecs[2] = '{"p16_1",     11'd16,   11'd1,    1'b1, 1'b0, 16'd0,     16'h0000, 1'b1, 16'd51,    16'h0003};
        vecs[3] = '{"p799_479",  11'd799,  11'd479,  1'b0, 1'b1, 16'd23999, 16'hFFFF, 1'b1, 16'd23999, 16'h7FFF};
        vecs[4] = '{"p800_0",    11'd800,  11'd0,    1'b1, 1'b0, 16'd0,     16'h0000, 1'b0, 16'd0,     16'h0000};
        vecs[5] = '{"p0_480",    11'd0,    11'd480,  1'b1, 1'b0, 16'd0,     16'h0000, 1'b0, 16'd0,     16'h0000};
        vecs[6] = '{"p5_0",      11'd5,    11'd0,    1'b1, 1'b1, 16'd0,     16'hFF00, 1'b1, 16'd0,     16'hFF20};
        vecs[7] = '{"p35_2",     11'd35,   11'd2,    1'b0, 1'b1, 16'd102,   16'hFFFF, 1'b1, 16'd102,   16'hFFF7};
        vecs[8] = '{"p2047_2047",11'd2047, 11'd2047, 1'b1, 1'b0, 16'd0,     16'h0000, 1'b0, 16'd0,     16'h0000};

        fill_start      = 1'b0;
        fill_val        = 1'b0;
        px_bus.px_valid = 1'b0;
        px_bus.px_x     = '0;
        px_bus.px_y     = '0;
        px_bus.px_val   = 1'b0;

        #2;
        check("rst_px_ready", 32'(px_bus.px_ready), 32'd1);
        check("rst_busy",     32'(busy),            32'd0);
        check("rst_done",     32'(done),            32'd0);
        check("rst_drop",     32'(drop),            32'd0);
        check("rst_we",       32'(ram_we),          32'd0);
        check("rst_wr_addr",  32'(ram_wr_addr),     32'd0);
        check("rst_wr_data",  32'(ram_wr_data),     32'd0);
        check("rst_rd_addr",  32'(ram_rd_addr),     32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_plot(vecs[i], waits);

        // Fill and a pixel request arrive together; fill must win.
        @(negedge clk);
        px_bus.px_x     = 11'd3;
        px_bus.px_y     = 11'd0;
        px_bus.px_val   = 1'b0;
        px_bus.px_valid = 1'b1;
        fill_start      = 1'b1;
        fill_val        = 1'b1;
        #1;
        check("fill_px_ready_forced_low", 32'(px_bus.px_ready), 32'd0);
        base_wr   = wr_cnt;
        base_done = done_cnt;
        @(negedge clk);
        fill_start = 1'b0;
        fill_val   = 1'b0;
        nwr       = 0;
        nerr      = 0;
        ndone_mid = 0;
        for (int c = 0; c < 30000 && busy; c++) begin
            if (px_bus.px_ready) nerr++;
            if (ram_we) begin
                if (ram_wr_addr !== 16'(nwr) || ram_wr_data !== 16'hFFFF) nerr++;
                nwr++;
            end
            if (done) ndone_mid++;
            @(negedge clk);
        end
        check("fill_busy_fell",   32'(busy),              32'd0);
        check("fill_write_count", 32'(nwr),               32'd24000);
        check("fill_total_wr",    32'(wr_cnt - base_wr),  32'd24000);
        check("fill_seq_errors",  32'(nerr),              32'd0);
        check("fill_done_early",  32'(ndone_mid),         32'd0);
        check("fill_done",        32'(done),              32'd1);
        check("fill_done_count",  32'(done_cnt - base_done), 32'd0);
        fv = '{"held_px", 11'd3, 11'd0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 16'd0, 16'hFFF7};
        run_plot(fv, waits);
        check("held_px_wait", 32'(waits), 32'd0);
        check("fill_done_once", 32'(done_cnt - base_done), 32'd1);

        // Reset in the middle of a fill.
        @(negedge clk);
        fill_start = 1'b1;
        fill_val   = 1'b0;
        @(negedge clk);
        fill_start = 1'b0;
        reached    = 1'b0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            if (ram_we && ram_wr_addr == 16'd1000) reached = 1'b1;
            else @(negedge clk);
        end
        check("rstmid_reached_1000", 32'(reached), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_we",       32'(ram_we),          32'd0);
        check("rstmid_busy",     32'(busy),            32'd0);
        check("rstmid_px_ready", 32'(px_bus.px_ready), 32'd1);
        check("rstmid_wr_addr",  32'(ram_wr_addr),     32'd0);
        base_wr = wr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_no_writes", 32'(wr_cnt - base_wr), 32'd0);
        check("rstmid_idle",      32'(busy),             32'd0);
        fv = '{"post_rst_p0_0", 11'd0, 11'd0, 1'b1, 1'b1, 16'd0, 16'h0000, 1'b1, 16'd0, 16'h0001};
        run_plot(fv, waits);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
Write-side controller for the 800x480 1-bpp frame buffer RAM (16 pixels per 16-bit word, LSB-first within a word). It accepts single-pixel plot requests over a valid/ready handshake and performs read-modify-write (RMW) on the addressed word. It also runs a full-screen fill engine. It owns the RAM write port and a dedicated RMW read port. The display scan read port is outside this block.

Parameters:
H_RES, 800, visible pixels per line
V_RES, 480, visible lines
ADDR_W, 16, RAM word-address width
WORDS (localparam), H_RES*V_RES/16 = 24000, frame size in words

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
px_valid  in  1  pixel request valid
px_ready  out  1  block can accept a pixel request this cycle
px_x  in  11  pixel column
px_y  in  11  pixel row
px_val  in  1  pixel value to store (1 = white)
fill_start  in  1  pulse: start full-screen fill
fill_val  in  1  fill value, sampled at fill_start
busy  out  1  block is not in IDLE
done  out  1  one-cycle pulse when a pixel op or fill completes
drop  out  1  one-cycle pulse when an out-of-range request is discarded
ram_rd_addr  out  ADDR_W  RMW read address
ram_rd_data  in  16  RMW read data; registered RAM, valid 1 cycle after address
ram_wr_addr  out  ADDR_W  write address
ram_wr_data  out  16  write data
ram_we  out  1  write enable

Behaviour:
- Reset values (async): state=IDLE; px_ready=1; busy=0; done=0; drop=0; ram_we=0; ram_wr_addr=0; ram_wr_data=0; ram_rd_addr=0.
- Address math: pn = px_x + px_y*800, 19-bit unsigned, no truncation. word = pn>>4, truncated to ADDR_W. bit = pn[3:0].
- States:
  - IDLE: px_ready=1.
    - fill_start=1 → FILL. Fill has priority; a px_valid in the same cycle is not accepted (px_ready is forced 0 that cycle).
    - Else px_valid=1 with px_x>=H_RES or px_y>=V_RES → request accepted, drop=1 on the next cycle, no RAM write, stay in IDLE.
    - Else px_valid=1 → latch word, bit and px_val; go to READ.
  - READ: ram_rd_addr=word; px_ready=0. Next state is MODIFY.
  - MODIFY: ram_we=1, ram_wr_addr=word, ram_wr_data = ram_rd_data with bit [bit] replaced by the latched px_val; other 15 bits unchanged. Next state is IDLE; done=1 on the next cycle.
  - Pixel op latency: 3 cycles from handshake edge to IDLE. Sustained rate: 1 pixel per 3 clocks.
  - FILL: counter runs 0..WORDS-1, one word per cycle. ram_we=1, ram_wr_addr=counter, ram_wr_data={16{fill_val latched}}. After counter=WORDS-1 is written, go to IDLE; done=1 on the next cycle. Exactly 24000 write cycles.
- busy=1 in READ, MODIFY and FILL. px_ready = (state==IDLE) && !fill_start.
- ram_we=0 in IDLE and READ.
- fill_start outside IDLE is ignored. px_valid outside IDLE is not accepted; the requester holds its request.
- Back-to-back RMW to the same word is coherent: each write lands before the next READ is issued. The RAM must return new data for a read issued the cycle after a write.
- Reset mid-operation: immediate return to reset values. A partial fill or a pending RMW is abandoned; no further writes occur.
- done and drop never assert in the same cycle.

Test Plan:
- RAM all 0. Plot (0,0) val=1 → exactly one write cycle: addr 0, data 0x0001. done 3 cycles after handshake. px_ready low for 2 cycles.
- Word 51 = 0x0000. Plot (17,1)=1 → addr 51, data 0x0002. Then plot (16,1)=1 back-to-back → addr 51, data 0x0003, proving RMW coherence.
- Word 23999 = 0xFFFF. Plot (799,479)=0 → addr 23999, data 0x7FFF.
- Plot (800,0) and then (0,480) → ram_we never asserts; drop pulses once per request; done stays 0.
- fill_start with fill_val=1 and px_valid in the same cycle:
  - pixel is not accepted;
  - 24000 consecutive writes, addresses 0..23999, data 0xFFFF;
  - done pulses once; busy then falls;
  - the held pixel request is accepted the following IDLE cycle.
- Assert reset at fill address 1000 → ram_we=0 and busy=0 immediately. After reset, a plot of (0,0) completes normally.
